// File: rtl/posit_stream_accumulator.sv
// Streaming posit summation engine: accumulates a packet of posit operands with
// round-to-nearest-even after every add and emits one result per packet.
module posit_stream_accumulator #(
  parameter int N     = 8,
  parameter int ES    = 0,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_nar
);

  localparam int FW  = N;            // left-aligned fraction field
  localparam int SW  = FW + 4;       // hidden one + fraction + guard/round/sticky
  localparam int TW  = ES + SW;
  localparam int VW  = 2 + TW + N;
  localparam int BW  = N - 1;
  localparam int SCW = 12;
  localparam logic [N-1:0] NAR = {1'b1, {(N-1){1'b0}}};

  typedef enum logic {ACCUM, HOLD} state_t;

  function automatic void posit_decode(input  logic [N-1:0]           p,
                                       output logic                   sgn,
                                       output logic signed [SCW-1:0]  scale,
                                       output logic [FW-1:0]          frac);
    logic [N-1:0]           mag;
    logic                   r0;
    logic                   run;
    int                     m;
    logic [63:0]            t;
    logic signed [SCW-1:0]  k;
    logic signed [SCW-1:0]  e;
    mag = p[N-1] ? -p : p;
    r0  = mag[N-2];
    run = 1'b1;
    m   = 0;
    for (int i = N - 2; i >= 0; i--) begin
      if (run && (mag[i] == r0)) m = m + 1;
      else run = 1'b0;
    end
    k = r0 ? SCW'(m - 1) : -SCW'(m);
    // drop sign, regime run and its terminator; exponent then fraction remain at the top
    t = {mag, {(64-N){1'b0}}} << (m + 2);
    e = (ES == 0) ? '0 : SCW'(t >> (64 - ES));
    sgn   = p[N-1];
    scale = (k <<< ES) + e;
    frac  = FW'((t << ES) >> (64 - FW));
  endfunction

  function automatic logic [N-1:0] posit_encode(input logic                  sgn,
                                                input logic signed [SCW-1:0] scale,
                                                input logic [SW-1:0]         frac);
    logic signed [SCW-1:0] k;
    logic signed [SCW-1:0] e;
    logic [TW-1:0]         tail;
    logic [VW-1:0]         v;
    logic [BW-1:0]         body;
    logic                  g;
    logic                  st;
    k = scale >>> ES;
    e = scale - (k <<< ES);
    v = '0;
    g = 1'b0;
    st = 1'b0;
    tail = '0;
    if (k >= SCW'(N - 2)) begin
      body = '1;
    end else if (k <= -SCW'(N - 1)) begin
      body = BW'(1);
    end else begin
      tail = (TW'(e) << SW) | TW'(frac);
      // regime built by shifting a 2-bit seed: sign-fill for runs of ones, zero-fill for zeros
      if (!k[SCW-1]) v = VW'($signed({2'b10, tail, {N{1'b0}}}) >>> k);
      else           v = {2'b01, tail, {N{1'b0}}} >> (-k - SCW'(1));
      body = v[VW-1 -: BW];
      g    = v[VW-N];
      st   = |v[VW-N-1:0];
      if (g && (st || body[0])) body = body + BW'(1);
    end
    return sgn ? -{1'b0, body} : {1'b0, body};
  endfunction

  function automatic logic [N-1:0] posit_add(input logic [N-1:0] a, input logic [N-1:0] b);
    logic                  sa, sb, sx, sy;
    logic signed [SCW-1:0] ea, eb, ex, ey;
    logic [FW-1:0]         fa, fb, fx, fy;
    logic [SW-1:0]         mx, my, ya;
    logic [SW:0]           sum, norm;
    int                    d, lead;
    logic [N-1:0]          res;
    posit_decode(a, sa, ea, fa);
    posit_decode(b, sb, eb, fb);
    if ((ea > eb) || ((ea == eb) && (fa >= fb))) begin
      sx = sa; ex = ea; fx = fa; sy = sb; ey = eb; fy = fb;
    end else begin
      sx = sb; ex = eb; fx = fb; sy = sa; ey = ea; fy = fa;
    end
    mx = {1'b1, fx, 3'b000};
    my = {1'b1, fy, 3'b000};
    d  = int'(ex - ey);
    if (d >= SW) ya = SW'(1);
    else         ya = (my >> d) | SW'(|(my & ((SW'(1) << d) - SW'(1))));
    sum  = (sx == sy) ? ({1'b0, mx} + {1'b0, ya}) : ({1'b0, mx} - {1'b0, ya});
    lead = 0;
    for (int i = 0; i <= SW; i++) begin
      if (sum[i]) lead = i;
    end
    norm = sum << (SW - lead);
    if ((a == NAR) || (b == NAR))                        res = NAR;
    else if (a == '0)                                    res = b;
    else if (b == '0)                                    res = a;
    else if ((sx != sy) && (ex == ey) && (fx == fy))     res = '0;
    else res = posit_encode(sx, ex + SCW'(lead - (SW - 1)), SW'(norm));
    return res;
  endfunction

  state_t             state_q, state_d;
  logic               s1_valid_q, s1_valid_d;
  logic [N-1:0]       s1_data_q, s1_data_d;
  logic               s1_last_q, s1_last_d;
  logic [N-1:0]       acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sticky_q, sticky_d;
  logic               out_valid_q, out_valid_d;
  logic [N-1:0]       out_data_q, out_data_d;
  logic [CNT_W-1:0]   out_count_q, out_count_d;
  logic               out_nar_q, out_nar_d;
  logic [N-1:0]       add_res;
  logic [CNT_W-1:0]   cnt_inc;
  logic               s1_nar;
  logic               xfer;

  assign in_ready = (state_q == ACCUM) & ~(s1_valid_q & s1_last_q) & ~clear & rst_n;
  assign xfer     = in_valid & in_ready;
  assign add_res  = posit_add(acc_q, s1_data_q);
  assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
  assign s1_nar   = (s1_data_q == NAR);

  always_comb begin
    state_d     = state_q;
    s1_valid_d  = xfer;
    s1_data_d   = s1_data_q;
    s1_last_d   = s1_last_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sticky_d    = sticky_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_nar_d   = out_nar_q;
    if (xfer) begin
      s1_data_d = in_data;
      s1_last_d = in_last;
    end
    // stage 2: accumulate, or close the packet on its last beat
    if (s1_valid_q) begin
      if (s1_last_q) begin
        out_data_d  = add_res;
        out_count_d = cnt_inc;
        out_nar_d   = sticky_q | s1_nar;
        out_valid_d = 1'b1;
        state_d     = HOLD;
        acc_d       = '0;
        cnt_d       = '0;
        sticky_d    = 1'b0;
      end else begin
        acc_d    = add_res;
        cnt_d    = cnt_inc;
        sticky_d = sticky_q | s1_nar;
      end
    end
    if ((state_q == HOLD) && out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      state_d     = ACCUM;
    end
    if (clear) begin
      s1_valid_d  = 1'b0;
      acc_d       = '0;
      cnt_d       = '0;
      sticky_d    = 1'b0;
      out_valid_d = 1'b0;
      state_d     = ACCUM;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      s1_valid_q  <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      sticky_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_nar_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      s1_valid_q  <= s1_valid_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sticky_q    <= sticky_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_nar_q   <= out_nar_d;
    end
    s1_data_q <= s1_data_d;
    s1_last_q <= s1_last_d;
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign out_nar   = out_nar_q;

endmodule

// File: tb/tb_posit_stream_accumulator.sv
// Directed bench for posit_stream_accumulator (N=8, ES=0): vector table of packets
// plus hand-written sequences for reset, latency, back-pressure and clear.
module tb_posit_stream_accumulator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [7:0] out_count;
  logic       out_nar;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    int             n;
    logic [0:3][7:0] b;
    logic [7:0]     exp_data;
    int             exp_cnt;
    logic           exp_nar;
  } vec_t;

  vec_t vecs[17];

  posit_stream_accumulator #(.N(8), .ES(0), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count), .out_nar(out_nar)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input int n, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3, input logic [7:0] e,
                         input int c, input logic nar);
    vecs[i].n = n;
    vecs[i].b = {b0, b1, b2, b3};
    vecs[i].exp_data = e;
    vecs[i].exp_cnt = c;
    vecs[i].exp_nar = nar;
  endtask

  // called #1 after a rising edge; returns #1 after the edge that transferred the beat
  task automatic put_beat(input logic [7:0] d, input logic last);
    int guard;
    guard = 0;
    in_data = d;
    in_last = last;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      n_vec++;
      n_fail++;
      $display("FAIL in_ready_timeout: got 0, expected 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic wait_out(input string name, output bit ok);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!out_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    ok = out_valid;
    if (!ok) begin
      n_vec++;
      n_fail++;
      $display("FAIL %s_timeout: out_valid got 0, expected 1", name);
    end
  endtask

  task automatic get_result(input string name, input logic [7:0] e, input int c, input logic nar);
    bit ok;
    wait_out(name, ok);
    if (ok) begin
      check({name, "_data"}, 32'(out_data), 32'(e));
      check({name, "_count"}, 32'(out_count), 32'(c));
      check({name, "_nar"}, 32'(out_nar), 32'(nar));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    bit ok;
    set_vec(0,  2, 8'h40, 8'h40, 8'h00, 8'h00, 8'h60, 2, 1'b0);
    set_vec(1,  2, 8'h7F, 8'h7F, 8'h00, 8'h00, 8'h7F, 2, 1'b0);
    set_vec(2,  2, 8'h01, 8'hFF, 8'h00, 8'h00, 8'h00, 2, 1'b0);
    set_vec(3,  2, 8'h50, 8'hB0, 8'h00, 8'h00, 8'h00, 2, 1'b0);
    set_vec(4,  1, 8'hC0, 8'h00, 8'h00, 8'h00, 8'hC0, 1, 1'b0);
    set_vec(5,  3, 8'h40, 8'h80, 8'h40, 8'h00, 8'h80, 3, 1'b1);
    set_vec(6,  1, 8'h40, 8'h00, 8'h00, 8'h00, 8'h40, 1, 1'b0);
    set_vec(7,  3, 8'h40, 8'h40, 8'h40, 8'h00, 8'h68, 3, 1'b0);
    set_vec(8,  2, 8'h01, 8'h01, 8'h00, 8'h00, 8'h02, 2, 1'b0);
    set_vec(9,  2, 8'h7E, 8'h01, 8'h00, 8'h00, 8'h7E, 2, 1'b0);
    set_vec(10, 2, 8'h40, 8'h42, 8'h00, 8'h00, 8'h60, 2, 1'b0);
    set_vec(11, 2, 8'h40, 8'h46, 8'h00, 8'h00, 8'h62, 2, 1'b0);
    set_vec(12, 2, 8'hC0, 8'hC0, 8'h00, 8'h00, 8'hA0, 2, 1'b0);
    set_vec(13, 2, 8'h60, 8'hC0, 8'h00, 8'h00, 8'h40, 2, 1'b0);
    set_vec(14, 2, 8'h81, 8'h81, 8'h00, 8'h00, 8'h81, 2, 1'b0);
    set_vec(15, 2, 8'h02, 8'hFF, 8'h00, 8'h00, 8'h01, 2, 1'b0);
    set_vec(16, 4, 8'h00, 8'h48, 8'h00, 8'h00, 8'h48, 4, 1'b0);

    rst_n = 1'b0;
    clear = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    in_last = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_out_nar", 32'(out_nar), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("release_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // latency: out_valid low after the transfer edge, high one edge later
    put_beat(8'h40, 1'b0);
    put_beat(8'h40, 1'b1);
    @(negedge clk);
    check("lat_valid_t1", 32'(out_valid), 32'd0);
    check("lat_in_ready_busy", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("lat_valid_t2", 32'(out_valid), 32'd1);
    get_result("lat", 8'h60, 2, 1'b0);

    for (int i = 0; i < 17; i++) begin
      for (int j = 0; j < vecs[i].n; j++) begin
        put_beat(vecs[i].b[j], (j == vecs[i].n - 1));
      end
      get_result($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_cnt, vecs[i].exp_nar);
    end

    // back-pressure: result held for 5 cycles, next-packet beat refused
    put_beat(8'h40, 1'b0);
    put_beat(8'h40, 1'b1);
    wait_out("hold", ok);
    in_valid = 1'b1;
    in_data = 8'h11;
    in_last = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("hold%0d_valid", c), 32'(out_valid), 32'd1);
      check($sformatf("hold%0d_data", c), 32'(out_data), 32'h60);
      check($sformatf("hold%0d_count", c), 32'(out_count), 32'd2);
      check($sformatf("hold%0d_in_ready", c), 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("release_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("release_in_ready2", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // clear with an accumulated beat in flight
    put_beat(8'h40, 1'b0);
    clear = 1'b1;
    @(negedge clk);
    check("clear_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    clear = 1'b0;
    put_beat(8'h60, 1'b1);
    get_result("clear_flush", 8'h60, 1, 1'b0);

    // clear discards a pending result
    put_beat(8'h40, 1'b1);
    wait_out("clr_hold", ok);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    @(negedge clk);
    check("clear_hold_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;

    // clear coinciding with the last-beat accumulation wins
    put_beat(8'h40, 1'b1);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("clear_last%0d_valid", c), 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    put_beat(8'h48, 1'b1);
    get_result("after_clear_last", 8'h48, 1, 1'b0);

    // reset in the middle of a packet
    put_beat(8'h40, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_data", 32'(out_data), 32'd0);
    check("midrst_out_count", 32'(out_count), 32'd0);
    check("midrst_out_nar", 32'(out_nar), 32'd0);
    repeat (3) @(negedge clk);
    check("midrst_no_result", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    put_beat(8'h40, 1'b1);
    get_result("after_midrst", 8'h40, 1, 1'b0);

    // beat counter saturates at 255
    for (int j = 0; j < 300; j++) begin
      put_beat(8'h00, (j == 299));
    end
    get_result("cnt_sat", 8'h00, 255, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time exceeded");
    $fatal(1, "timeout");
  end

endmodule
